dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single data memory.
// One transaction in flight at a time: IDLE (grant) -> ACCESS (memory strobe) -> RESP.
// Misaligned or out-of-range requests skip ACCESS and answer with an error in RESP.
// Ports:
//   clkR, resetn                      clock, async active-low reset
//   reqN_valid/ready/we/op/addr/wdata request channel, N=0 core LSU, N=1 debug/loader
//   rspN_valid/err/rdata              one-cycle response pulse to the owning requester
//   mem_MemWr/MemOP/addr/wdata        registered memory command, valid in ACCESS
//   mem_rdata                         memory read data, registered by the memory
module dmem_arbiter #(
    parameter int unsigned DEPTH = 2048
) (
    input  logic        clkR,
    input  logic        resetn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic        rsp0_err,
    output logic [31:0] rsp0_rdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic        rsp1_err,
    output logic [31:0] rsp1_rdata,
    output logic        mem_MemWr,
    output logic [2:0]  mem_MemOP,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] LAST_ADDR = 33'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        rr_prio;    // 1: requester 1 has priority on the next grant
    logic        owner;
    logic        we_q;
    logic [2:0]  op_q;

    logic        grant1_c;
    logic        accept_c;
    logic        sel_we_c;
    logic [2:0]  sel_op_c;
    logic [31:0] sel_addr_c;
    logic [31:0] sel_wdata_c;
    logic [32:0] size_c;
    logic [32:0] last_c;
    logic        err_c;
    logic [31:0] load_c;

    // Round-robin winner and request mux
    always_comb begin
        grant1_c    = rr_prio ? req1_valid : !req0_valid;
        req0_ready  = (state == IDLE) && !grant1_c && req0_valid;
        req1_ready  = (state == IDLE) &&  grant1_c && req1_valid;
        accept_c    = req0_ready || req1_ready;
        sel_we_c    = grant1_c ? req1_we    : req0_we;
        sel_op_c    = grant1_c ? req1_op    : req0_op;
        sel_addr_c  = grant1_c ? req1_addr  : req0_addr;
        sel_wdata_c = grant1_c ? req1_wdata : req0_wdata;
    end

    // Alignment and range check; 33-bit sum so addresses near 2^32 cannot wrap
    always_comb begin
        size_c = sel_op_c[2] ? 33'd4 : (sel_op_c[1] ? 33'd2 : 33'd1);
        last_c = {1'b0, sel_addr_c} + size_c - 33'd1;
        err_c  = (sel_op_c[2] && (sel_addr_c[1:0] != 2'b00)) ||
                 (sel_op_c[1] && sel_addr_c[0]) ||
                 (last_c > LAST_ADDR);
    end

    // Load extraction and extension from the memory's registered read data
    always_comb begin
        load_c = 32'd0;
        if (op_q[2]) begin
            load_c = mem_rdata;
        end else if (op_q[1]) begin
            load_c = op_q[0] ? {{16{mem_rdata[15]}}, mem_rdata[15:0]}
                             : {16'd0, mem_rdata[15:0]};
        end else begin
            load_c = op_q[0] ? {{24{mem_rdata[7]}}, mem_rdata[7:0]}
                             : {24'd0, mem_rdata[7:0]};
        end
    end

    // Read data is forced to zero outside a successful load response
    assign rsp0_rdata = (rsp0_valid && !rsp0_err && !we_q) ? load_c : 32'd0;
    assign rsp1_rdata = (rsp1_valid && !rsp1_err && !we_q) ? load_c : 32'd0;

    // Transaction FSM with registered memory command and response flags
    always_ff @(posedge clkR or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rr_prio    <= 1'b0;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            op_q       <= 3'd0;
            mem_MemWr  <= 1'b0;
            mem_MemOP  <= 3'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        owner   <= grant1_c;
                        we_q    <= sel_we_c;
                        op_q    <= sel_op_c;
                        rr_prio <= !grant1_c;
                        if (err_c) begin
                            state      <= RESP;
                            rsp0_valid <= !grant1_c;
                            rsp1_valid <= grant1_c;
                            rsp0_err   <= !grant1_c;
                            rsp1_err   <= grant1_c;
                        end else begin
                            state     <= ACCESS;
                            mem_MemWr <= sel_we_c;
                            mem_MemOP <= {sel_op_c[2], sel_op_c[2] | sel_op_c[1], 1'b0};
                            mem_addr  <= sel_addr_c;
                            mem_wdata <= sel_wdata_c;
                        end
                    end
                end
                ACCESS: begin
                    state      <= RESP;
                    mem_MemWr  <= 1'b0;
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    rsp0_err   <= 1'b0;
                    rsp1_err   <= 1'b0;
                end
                RESP: begin
                    state      <= IDLE;
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    rsp0_err   <= 1'b0;
                    rsp1_err   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_MemWr <= 1'b0;
                end
            endcase
        end
    end

endmodule
